approx_mul_seq: RTL



---
 rtl/approx_mul_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/approx_mul_seq.sv
// Sequential approximate unsigned multiplier: one partial-product row pair per cycle,
// with per-column approximation of the row-pair overlap, accumulated into a 2W-bit product.
module approx_mul_seq #(
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [W-1:0]       y,
  input  logic [2*(W-1)-1:0] cfg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     p,
  output logic               busy
);

  localparam int unsigned KW = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [KW-1:0] LastK = KW'(W / 2 - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e              state_q;
  logic [KW-1:0]       k_q;
  logic [W-1:0]        x_q, y_q;
  logic [2*(W-1)-1:0]  cfg_q;
  logic [2*W-1:0]      acc_q;
  logic                out_valid_q, busy_q;

  logic [W-1:0]   xs, a, b;
  logic [W:0]     sum, carry;
  logic [W+1:0]   pair;
  logic [2*W-1:0] pair_ext, acc_d;

  // Column reduction of the current row pair; b sits one bit above a.
  always_comb begin
    xs    = x_q >> (2 * k_q);
    a     = y_q & {W{xs[0]}};
    b     = y_q & {W{xs[1]}};
    sum   = '0;
    carry = '0;
    sum[0] = a[0];
    sum[W] = b[W-1];
    for (int j = 1; j < W; j++) begin
      unique case (cfg_q[2*(j-1) +: 2])
        2'b00: begin
          sum[j]   = a[j] ^ b[j-1];
          carry[j] = a[j] & b[j-1];
        end
        2'b01:   sum[j] = a[j] | b[j-1];
        2'b10:   sum[j] = 1'b0;
        default: sum[j] = a[j];
      endcase
    end
    pair     = {1'b0, sum} + {carry, 1'b0};
    pair_ext = {{(W-2){1'b0}}, pair};
    acc_d    = acc_q + (pair_ext << (2 * k_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cfg_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q     <= x;
            y_q     <= y;
            cfg_q   <= cfg;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= StCompute;
          end
        end
        StCompute: begin
          acc_q <= acc_d;
          if (k_q == LastK) begin
            k_q         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = acc_q;

endmodule
